// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Drives the load/flush enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. Resolves load-use hazards, ID-stage branch redirects and
// multi-cycle data-memory waits, with a wait timeout and stall-cycle counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_rs, id_rt          source fields of the instruction in ID
//   id_uses_rt            ID instruction reads rt
//   id_branch_taken       ID resolved a taken branch/jump this cycle
//   ex_mem_read, ex_rt    load in EX and its destination register
//   mem_req, dmem_ready   MEM-stage access in flight / completing
//   pc_load ... mem_wb_flush  pipeline register enables (combinational)
//   mem_error             sticky memory-wait timeout flag
//   stall_cycles          saturating count of cycles with pc_load=0
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_load,
  output logic             id_ex_flush,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             mem_wb_flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic              mem_stall;
  logic              load_use;

  // Hazard detection
  assign mem_stall = mem_req & ~dmem_ready;
  assign load_use  = ex_mem_read & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign wait_cnt_inc = WAIT_W'(wait_cnt + WAIT_W'(1));

  // State, wait counter, stall counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      mem_error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == S_ERR) begin
        mem_error <= 1'b1;
      end
      if (!pc_load && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= CNT_W'(stall_cycles + CNT_W'(1));
      end
    end
  end

  // Next state and pipeline enables; priority mem_stall > load_use > branch
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_load      = 1'b1;
    if_id_load   = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_load   = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_load  = 1'b1;
    mem_wb_load  = 1'b1;
    mem_wb_flush = 1'b0;

    case (state)
      S_RUN, S_MEM_WAIT: begin
        if (mem_stall) begin
          // Freeze the front; bubble into MEM/WB so the stalled access is
          // not written back twice.
          pc_load      = 1'b0;
          if_id_load   = 1'b0;
          id_ex_load   = 1'b0;
          ex_mem_load  = 1'b0;
          mem_wb_flush = 1'b1;
        end else if (load_use) begin
          pc_load     = 1'b0;
          if_id_load  = 1'b0;
          id_ex_flush = 1'b1;
        end else if (id_branch_taken) begin
          if_id_flush = 1'b1;
        end

        if (state == S_RUN) begin
          if (mem_stall) begin
            state_nxt    = S_MEM_WAIT;
            wait_cnt_nxt = WAIT_W'(1);
          end
        end else begin
          // A dropped mem_req also counts as completion.
          if (!mem_stall) begin
            state_nxt    = S_RUN;
            wait_cnt_nxt = '0;
          end else if (wait_cnt_inc >= WAIT_W'(MEM_TIMEOUT)) begin
            state_nxt    = S_ERR;
            wait_cnt_nxt = wait_cnt_inc;
          end else begin
            wait_cnt_nxt = wait_cnt_inc;
          end
        end
      end

      S_ERR: begin
        pc_load     = 1'b0;
        if_id_load  = 1'b0;
        id_ex_load  = 1'b0;
        ex_mem_load = 1'b0;
        mem_wb_load = 1'b0;
      end

      default: begin
        state_nxt    = S_ERR;
        pc_load      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_load   = 1'b0;
        ex_mem_load  = 1'b0;
        mem_wb_load  = 1'b0;
      end
    endcase

    // Hold the whole pipeline in reset: nothing loads, everything flushes.
    if (!rst_n) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_load   = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      mem_wb_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // Enable vector order: pc, if_id_load, if_id_flush, id_ex_load,
  // id_ex_flush, ex_mem_load, mem_wb_load, mem_wb_flush
  localparam logic [7:0] V_NORM = 8'b1101_0110;
  localparam logic [7:0] V_RST  = 8'b0010_1001;
  localparam logic [7:0] V_MST  = 8'b0000_0011;
  localparam logic [7:0] V_LU   = 8'b0001_1110;
  localparam logic [7:0] V_BR   = 8'b1111_0110;
  localparam logic [7:0] V_ERR  = 8'b0000_0000;

  typedef struct packed {
    logic [7:0]       ctrl;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, id_branch_taken, ex_mem_read;
  logic             mem_req, dmem_ready;
  logic             pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush;
  logic             ex_mem_load, mem_wb_load, mem_wb_flush, mem_error;
  logic [CNT_W-1:0] stall_cycles;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch_taken(id_branch_taken),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_load(pc_load), .if_id_load(if_id_load), .if_id_flush(if_id_flush),
    .id_ex_load(id_ex_load), .id_ex_flush(id_ex_flush),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .mem_wb_flush(mem_wb_flush), .mem_error(mem_error),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic br, input logic mrd,
                        input logic [4:0] ert, input logic req, input logic rdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_branch_taken = br;
    ex_mem_read = mrd; ex_rt = ert; mem_req = req; dmem_ready = rdy;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  // Queue the expectation for the current inputs, compare mid-cycle, then
  // advance past the next rising edge.
  task automatic step(input string tag, input logic [7:0] ctrl,
                      input logic err, input int cnt);
    exp_t e, got;
    logic [7:0] obs;
    e.ctrl = ctrl; e.err = err; e.cnt = CNT_W'(cnt);
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    obs = {pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
           ex_mem_load, mem_wb_load, mem_wb_flush};
    checks++;
    assert (obs === got.ctrl) else begin
      failures++;
      $error("FAIL %s enables observed=%b expected=%b", tag, obs, got.ctrl);
    end
    checks++;
    assert (mem_error === got.err) else begin
      failures++;
      $error("FAIL %s mem_error observed=%b expected=%b", tag, mem_error, got.err);
    end
    checks++;
    assert (stall_cycles === got.cnt) else begin
      failures++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, got.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    step("reset_hold", V_RST, 1'b0, 0);
    rst_n = 1'b1;
    step("reset_release", V_NORM, 1'b0, 0);

    // Load-use on rs
    set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    step("lu_rs", V_LU, 1'b0, 0);
    set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1);
    step("lu_bubble", V_NORM, 1'b0, 1);
    // r0 destination never stalls
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
    step("lu_r0", V_NORM, 1'b0, 1);
    // rt match ignored when rt is not a source
    set_in(5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    step("lu_rt_unused", V_NORM, 1'b0, 1);
    set_in(5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    step("lu_rt_used", V_LU, 1'b0, 1);

    // Branch alone, then branch with concurrent load-use
    set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    step("branch", V_BR, 1'b0, 2);
    set_in(5'd8, 5'd4, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1);
    step("branch_lu", V_LU, 1'b0, 2);
    idle();
    step("idle1", V_NORM, 1'b0, 3);

    // Three-cycle memory wait; branch/load-use ignored while frozen
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("mw1", V_MST, 1'b0, 3);
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    step("mw2", V_MST, 1'b0, 4);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("mw3", V_MST, 1'b0, 5);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("mw_done", V_NORM, 1'b0, 6);
    idle();
    step("idle2", V_NORM, 1'b0, 6);

    // mem_req dropping ends the wait
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("drop1", V_MST, 1'b0, 6);
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step("drop_done", V_BR, 1'b0, 7);

    // Reset in the middle of a wait (counter=3)
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("rw1", V_MST, 1'b0, 7);
    step("rw2", V_MST, 1'b0, 8);
    step("rw3", V_MST, 1'b0, 9);
    rst_n = 1'b0;
    step("rw_reset", V_RST, 1'b0, 0);
    rst_n = 1'b1;
    idle();
    step("rw_release", V_NORM, 1'b0, 0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("rw_run", V_NORM, 1'b0, 0);

    // Timeout: four stalled cycles, then ERR
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("to1", V_MST, 1'b0, 0);
    step("to2", V_MST, 1'b0, 1);
    step("to3", V_MST, 1'b0, 2);
    step("to4", V_MST, 1'b0, 3);
    idle();
    // ERR is sticky; stall counter saturates at 15
    for (int k = 1; k <= 20; k++) begin
      step("err_hold", V_ERR, 1'b1, (3 + k > 15) ? 15 : 3 + k);
    end

    rst_n = 1'b0;
    step("err_reset", V_RST, 1'b0, 0);
    rst_n = 1'b1;
    step("err_release", V_NORM, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
